// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The master issues operands and start; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock,
// through a single registered full-adder cell computing a + ~b + carry.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | processing one operand bit per clock; busy=1
// DONE  | results valid and done=1 for one cycle
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q, zero_q;

  logic             sum, carry_nxt, last, accept;
  logic             ready_c, busy_c, done_c;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    sum       = a_sh[0] ^ ~b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);
    res_nxt   = {sum, res_sh[WIDTH-1:1]};
    last      = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the final bit, a_sh[0]/b_sh[0] hold the original operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= carry_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff_q     <= res_nxt;
        borrow_q   <= ~carry_nxt;
        overflow_q <= (a_sh[0] != b_sh[0]) && (sum != a_sh[0]);
        zero_q     <= (res_nxt == '0);
      end
    end
  end

  assign bus.ready      = ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at each accept
// edge and compared when done pulses.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   acc_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   n_acc       = 0;
  int   last_acc    = -1;
  bit   hold_mode   = 1'b0;
  bit   prev_done   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d  = a - b;
    e.br = (a < b);
    e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    e.z  = (e.d == '0);
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   c;
    cyc++;
    if (rst_n && bus.ready && bus.start) begin
      sb.push_back(model(bus.a, bus.b));
      acc_q.push_back(cyc);
      n_acc++;
      if (hold_mode && last_acc >= 0) check("accept_spacing", cyc - last_acc, 10);
      last_acc = cyc;
    end
    #1;
    if (hold_mode && (bus.busy || bus.done)) check("ready_low_in_op", bus.ready, 0);
    if (bus.done) begin
      check("done_single_pulse", prev_done, 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        c = acc_q.pop_front();
        check("latency", cyc - c, W);
        check("diff", bus.diff, e.d);
        check("borrow", bus.borrow_out, e.br);
        check("overflow", bus.overflow, e.ov);
        check("zero", bus.zero, e.z);
        check("ready_in_done", bus.ready, 0);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && bus.ready) return;
      @(negedge clk);
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, bus.ready, 1);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
    check({pfx, "_diff"}, bus.diff, 0);
    check({pfx, "_borrow"}, bus.borrow_out, 0);
    check({pfx, "_overflow"}, bus.overflow, 0);
    check({pfx, "_zero"}, bus.zero, 0);
  endtask

  initial begin
    int acc_before;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'h05, 8'h03);
    op(8'h03, 8'h05);
    op(8'h80, 8'h01);
    op(8'h7F, 8'hFF);
    op(8'hA5, 8'hA5);
    op(8'h00, 8'h00);
    op(8'hFF, 8'h00);
    op(8'h00, 8'hFF);
    for (int i = 0; i < 6; i++) op(W'($urandom), W'($urandom));

    // start held high with operands changing every cycle
    wait_ready();
    hold_mode = 1'b1;
    last_acc  = -1;
    bus.start = 1'b1;
    for (int i = 0; i < 41; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();
    hold_mode = 1'b0;

    // operands and start disturbed mid-run
    wait_ready();
    acc_before = n_acc;
    bus.a      = 8'h3C;
    bus.b      = 8'h5A;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'h11;
    wait_idle();
    check("no_extra_accept", n_acc - acc_before, 1);

    // reset in the middle of an operation
    wait_ready();
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrun_rst");
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    op(8'h40, 8'h41);
    op(8'h81, 8'h7F);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
